// File: rtl/gate_accum_pkg.sv
// gate_accum shared types: logic-function modes, base ops, FSM states.
// Helper functions map a mode to its base op and output inversion.
package gate_accum_pkg;

    localparam int MAX_W = 32;

    typedef enum logic [2:0] {
        MODE_AND  = 3'd0,
        MODE_OR   = 3'd1,
        MODE_XOR  = 3'd2,
        MODE_NAND = 3'd3,
        MODE_NOR  = 3'd4,
        MODE_XNOR = 3'd5,
        MODE_RSV6 = 3'd6,
        MODE_RSV7 = 3'd7
    } mode_e;

    typedef enum logic [1:0] {
        OP_AND = 2'd0,
        OP_OR  = 2'd1,
        OP_XOR = 2'd2
    } base_op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_e;

    // Reserved modes fall back to OR.
    function automatic base_op_e base_op_of(input logic [2:0] m);
        base_op_e op;
        case (mode_e'(m))
            MODE_AND, MODE_NAND: op = OP_AND;
            MODE_XOR, MODE_XNOR: op = OP_XOR;
            default:             op = OP_OR;
        endcase
        return op;
    endfunction

    function automatic logic is_inverted(input logic [2:0] m);
        return (m == MODE_NAND) || (m == MODE_NOR) || (m == MODE_XNOR);
    endfunction

    // Operands are zero-extended to MAX_W; callers truncate the result.
    function automatic logic [MAX_W-1:0] apply_op(
        input base_op_e         op,
        input logic [MAX_W-1:0] a,
        input logic [MAX_W-1:0] b
    );
        logic [MAX_W-1:0] r;
        case (op)
            OP_AND:  r = a & b;
            OP_XOR:  r = a ^ b;
            default: r = a | b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/gate_accum_lane_reduce.sv
// lane_reduce: folds N_IN lanes of WIDTH bits into one WIDTH-bit word
// using the selected base op (no inversion applied here).
module lane_reduce
    import gate_accum_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_IN  = 2
) (
    input  base_op_e                op,
    input  logic [N_IN*WIDTH-1:0]   data,
    output logic [WIDTH-1:0]        result
);

    // Left-to-right fold of every lane into lane 0.
    always_comb begin
        result = data[0 +: WIDTH];
        for (int k = 1; k < N_IN; k++) begin
            result = WIDTH'(apply_op(op,
                                     MAX_W'(result),
                                     MAX_W'(data[k*WIDTH +: WIDTH])));
        end
    end

endmodule

// File: rtl/gate_accum.sv
// gate_accum: per-beat lane reduce, accumulated over a frame ending on
// in_last. Optional beat counter: define GATE_ACCUM_BEAT_COUNT_EN.
module gate_accum
    import gate_accum_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int N_IN    = 2
`ifdef GATE_ACCUM_BEAT_COUNT_EN
    ,
    parameter int COUNT_W = 8
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2:0]             mode,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_IN*WIDTH-1:0]  in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data
`ifdef GATE_ACCUM_BEAT_COUNT_EN
    ,
    output logic [COUNT_W-1:0]     out_count
`endif
);

    state_e           state;
    state_e           state_n;
    logic [2:0]       mode_q;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_n;
    logic [WIDTH-1:0] beat_res;
    base_op_e         op_sel;
    logic             inv_sel;
    logic             accept;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // The first beat of a frame uses the live mode; later beats the latched one.
    always_comb begin
        op_sel  = base_op_of(mode_q);
        inv_sel = is_inverted(mode_q);
        if (state == ST_IDLE) begin
            op_sel  = base_op_of(mode);
            inv_sel = is_inverted(mode);
        end
    end

    lane_reduce #(
        .WIDTH (WIDTH),
        .N_IN  (N_IN)
    ) u_reduce (
        .op     (op_sel),
        .data   (in_data),
        .result (beat_res)
    );

    // Next accumulator value: load on frame open, fold otherwise.
    always_comb begin
        acc_n = beat_res;
        if (state == ST_ACCUM) begin
            acc_n = WIDTH'(apply_op(op_sel, MAX_W'(acc), MAX_W'(beat_res)));
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    // Next-state logic: a frame is open between first and last beat.
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:  if (accept && !in_last) state_n = ST_ACCUM;
            ST_ACCUM: if (accept && in_last)  state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    // Accumulator, latched mode and the held output result.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            mode_q    <= MODE_AND;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;
            if (accept) begin
                acc <= acc_n;
                if (state == ST_IDLE) mode_q <= mode;
                if (in_last) begin
                    out_valid <= 1'b1;
                    out_data  <= inv_sel ? ~acc_n : acc_n;
                end
            end
        end
    end

`ifdef GATE_ACCUM_BEAT_COUNT_EN
    logic [COUNT_W-1:0] cnt;
    logic [COUNT_W-1:0] cnt_n;

    // Beat count restarts at 1 per frame and saturates at all-ones.
    always_comb begin
        cnt_n = COUNT_W'(1);
        if (state == ST_ACCUM) begin
            cnt_n = (&cnt) ? cnt : cnt + COUNT_W'(1);
        end
    end

    // Running count, copied to out_count alongside out_data.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            out_count <= '0;
        end else if (accept) begin
            cnt <= cnt_n;
            if (in_last) out_count <= cnt_n;
        end
    end
`endif

endmodule

// File: tb/tb_gate_accum.sv
// Directed bench for gate_accum (WIDTH=8, N_IN=2).
// Count checks are active when GATE_ACCUM_BEAT_COUNT_EN is defined.
module tb_gate_accum;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  mode;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
`ifdef GATE_ACCUM_BEAT_COUNT_EN
    logic [7:0]  out_count;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gate_accum #(
        .WIDTH   (8),
        .N_IN    (2)
`ifdef GATE_ACCUM_BEAT_COUNT_EN
        ,
        .COUNT_W (8)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef GATE_ACCUM_BEAT_COUNT_EN
        ,
        .out_count (out_count)
`endif
    );

    // One beat offered for exactly one rising edge (in_ready assumed high).
    task automatic send(input logic [7:0] l0, input logic [7:0] l1,
                        input logic last, input logic [2:0] m);
        in_valid = 1'b1;
        in_data  = {l1, l0};
        in_last  = last;
        mode     = m;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_valid got=%b exp=0", out_valid);
        end
        total++;
        if (out_data !== 8'h00) begin
            bad++; $display("FAIL reset_data got=%h exp=00", out_data);
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_ready got=%b exp=1", in_ready);
        end
`ifdef GATE_ACCUM_BEAT_COUNT_EN
        total++;
        if (out_count !== 8'h00) begin
            bad++; $display("FAIL reset_count got=%h exp=00", out_count);
        end
`endif
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_or_single();
        send(8'h0F, 8'hF0, 1'b1, 3'd1);
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1) begin
            bad++; $display("FAIL or_valid got=%b exp=1", out_valid);
        end
        total++;
        if (out_data !== 8'hFF) begin
            bad++; $display("FAIL or_data got=%h exp=ff", out_data);
        end
`ifdef GATE_ACCUM_BEAT_COUNT_EN
        total++;
        if (out_count !== 8'd1) begin
            bad++; $display("FAIL or_count got=%0d exp=1", out_count);
        end
`endif
    endtask

    task automatic test_and_multi();
        @(posedge clk);
        #1;
        send(8'hFF, 8'hF3, 1'b0, 3'd0);
        send(8'hF1, 8'hFF, 1'b0, 3'd0);
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL and_midframe_valid got=%b exp=0", out_valid);
        end
        @(posedge clk);
        #1;
        send(8'h7F, 8'hFF, 1'b1, 3'd0);
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'h71) begin
            bad++;
            $display("FAIL and_data got=%b/%h exp=1/71", out_valid, out_data);
        end
`ifdef GATE_ACCUM_BEAT_COUNT_EN
        total++;
        if (out_count !== 8'd3) begin
            bad++; $display("FAIL and_count got=%0d exp=3", out_count);
        end
`endif
    endtask

    task automatic test_mode_ignore();
        @(posedge clk);
        #1;
        send(8'h00, 8'h01, 1'b0, 3'd4);
        send(8'h80, 8'h00, 1'b1, 3'd0);
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'h7E) begin
            bad++;
            $display("FAIL nor_data got=%b/%h exp=1/7e", out_valid, out_data);
        end
`ifdef GATE_ACCUM_BEAT_COUNT_EN
        total++;
        if (out_count !== 8'd2) begin
            bad++; $display("FAIL nor_count got=%0d exp=2", out_count);
        end
`endif
    endtask

    task automatic test_backpressure();
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(8'h0F, 8'h00, 1'b1, 3'd2);
        in_valid = 1'b1;
        in_data  = {8'h3C, 8'h00};
        in_last  = 1'b1;
        mode     = 3'd1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (in_ready !== 1'b0) begin
                bad++; $display("FAIL bp_ready[%0d] got=%b exp=0", i, in_ready);
            end
            total++;
            if (out_valid !== 1'b1 || out_data !== 8'h0F) begin
                bad++;
                $display("FAIL bp_hold[%0d] got=%b/%h exp=1/0f",
                         i, out_valid, out_data);
            end
        end
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL bp_release_ready got=%b exp=1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'h3C) begin
            bad++;
            $display("FAIL bp_second got=%b/%h exp=1/3c", out_valid, out_data);
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL bp_drained got=%b exp=0", out_valid);
        end
    endtask

    task automatic test_reset_mid_frame();
        @(posedge clk);
        #1;
        send(8'h01, 8'h00, 1'b0, 3'd1);
        send(8'h02, 8'h00, 1'b0, 3'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL rst_mid_valid got=%b exp=0", out_valid);
        end
        send(8'hAA, 8'h55, 1'b1, 3'd2);
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'hFF) begin
            bad++;
            $display("FAIL rst_xor got=%b/%h exp=1/ff", out_valid, out_data);
        end
`ifdef GATE_ACCUM_BEAT_COUNT_EN
        total++;
        if (out_count !== 8'd1) begin
            bad++; $display("FAIL rst_count got=%0d exp=1", out_count);
        end
`endif
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL rst_single_result got=%b exp=0", out_valid);
        end
        // Reset coincides with an accepted last beat: no result.
        in_valid = 1'b1;
        in_data  = {8'h12, 8'h34};
        in_last  = 1'b1;
        mode     = 3'd1;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || out_data !== 8'h00) begin
            bad++;
            $display("FAIL rst_wins got=%b/%h exp=0/00", out_valid, out_data);
        end
    endtask

    task automatic test_reserved_mode();
        @(posedge clk);
        #1;
        send(8'h01, 8'h02, 1'b1, 3'd6);
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'h03) begin
            bad++;
            $display("FAIL rsv6_data got=%b/%h exp=1/03", out_valid, out_data);
        end
        @(posedge clk);
        #1;
        send(8'h40, 8'h04, 1'b1, 3'd7);
        @(negedge clk);
        total++;
        if (out_data !== 8'h44) begin
            bad++; $display("FAIL rsv7_data got=%h exp=44", out_data);
        end
    endtask

    task automatic test_saturation();
        logic [7:0] one;
        @(posedge clk);
        #1;
        one = 8'h01;
        for (int i = 0; i < 300; i++) begin
            send(one << (i % 8), 8'h00, (i == 299), 3'd6);
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'hFF) begin
            bad++;
            $display("FAIL sat_data got=%b/%h exp=1/ff", out_valid, out_data);
        end
`ifdef GATE_ACCUM_BEAT_COUNT_EN
        total++;
        if (out_count !== 8'hFF) begin
            bad++; $display("FAIL sat_count got=%h exp=ff", out_count);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] e;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a = 8'(8'h11 * i + 8'h05);
            b = 8'(8'hC3 ^ (i * 8'h21));
            e = ~(a ^ b);
            in_valid = 1'b1;
            in_last  = 1'b1;
            in_data  = {b, a};
            mode     = 3'd5;
            @(posedge clk);
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || out_data !== e || in_ready !== 1'b1) begin
                bad++;
                $display("FAIL b2b[%0d] got=%b/%h/%b exp=1/%h/1",
                         i, out_valid, out_data, in_ready, e);
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        mode      = 3'd0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_or_single();
        test_and_multi();
        test_mode_ignore();
        test_backpressure();
        test_reset_mid_frame();
        test_reserved_mode();
        test_saturation();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
